// File: rtl/heap_pkg.sv
// Shared types and index helpers for the heap_pq binary-heap priority queue.
package heap_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SIFT_UP   = 2'd1,
    SIFT_DOWN = 2'd2
  } state_t;

  function automatic int unsigned parent_of(input int unsigned i);
    return (i - 32'd1) >> 1;
  endfunction

  function automatic int unsigned left_of(input int unsigned i);
    return (i << 1) + 32'd1;
  endfunction

endpackage

// File: rtl/heap_cmp.sv
// Priority comparator: high when key a outranks key b; equal keys never outrank.
// HEAP_MIN_EN selects smallest-first ordering, otherwise largest-first.
module heap_cmp #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              higher
);

`ifdef HEAP_MIN_EN
  assign higher = (a < b);
`else
  assign higher = (a > b);
`endif

endmodule

// File: rtl/heap_pq.sv
// Sequential binary-heap priority queue with valid/ready push and pop streams.
// Ordering is max-first by default; define HEAP_MIN_EN for min-first.
module heap_pq
  import heap_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count,
  output logic              busy
);

  logic [DATA_W-1:0] arr [DEPTH];

  state_t            state, next_state;
  logic [IDX_W-1:0]  idx, next_idx;
  logic [CNT_W-1:0]  next_count;

  // Two write ports: a swap touches both the current node and its neighbour.
  logic              we_a, we_b;
  logic [IDX_W-1:0]  wa_idx, wb_idx;
  logic [DATA_W-1:0] wa_data, wb_data;
  logic [DATA_W-1:0] root_next;

  logic [IDX_W-1:0]  par_idx, l_idx, r_idx, last_idx, best_idx;
  int unsigned       left_full, right_full;
  logic              left_in, right_in, pick_right;
  logic [DATA_W-1:0] cur_val, par_val, l_val, r_val, best_val;
  logic              up_hi, rl_hi, dn_hi;
  logic              push, pop;

  assign par_idx    = IDX_W'(parent_of(32'(idx)));
  assign left_full  = left_of(32'(idx));
  assign right_full = left_full + 32'd1;
  assign l_idx      = IDX_W'(left_full);
  assign r_idx      = IDX_W'(right_full);
  assign left_in    = left_full < 32'(count);
  assign right_in   = right_full < 32'(count);
  assign last_idx   = IDX_W'(count - 1'b1);

  assign cur_val = arr[idx];
  assign par_val = arr[par_idx];
  assign l_val   = arr[l_idx];
  assign r_val   = arr[r_idx];

  heap_cmp #(.DATA_W(DATA_W)) u_cmp_up (.a(cur_val), .b(par_val), .higher(up_hi));
  heap_cmp #(.DATA_W(DATA_W)) u_cmp_rl (.a(r_val),   .b(l_val),   .higher(rl_hi));
  heap_cmp #(.DATA_W(DATA_W)) u_cmp_dn (.a(best_val), .b(cur_val), .higher(dn_hi));

  // The left child wins ties between siblings.
  assign pick_right = right_in && rl_hi;
  assign best_idx   = pick_right ? r_idx : l_idx;
  assign best_val   = pick_right ? r_val : l_val;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_count = count;
    we_a       = 1'b0;
    we_b       = 1'b0;
    wa_idx     = '0;
    wb_idx     = '0;
    wa_data    = '0;
    wb_data    = '0;
    unique case (state)
      IDLE: begin
        if (push && pop) begin
          we_a       = 1'b1;
          wa_idx     = '0;
          wa_data    = in_data;
          next_idx   = '0;
          next_state = SIFT_DOWN;
        end else if (push) begin
          we_a       = 1'b1;
          wa_idx     = IDX_W'(count);
          wa_data    = in_data;
          next_idx   = IDX_W'(count);
          next_count = count + 1'b1;
          next_state = SIFT_UP;
        end else if (pop) begin
          we_a       = 1'b1;
          wa_idx     = '0;
          wa_data    = arr[last_idx];
          next_idx   = '0;
          next_count = count - 1'b1;
          next_state = (count <= CNT_W'(2)) ? IDLE : SIFT_DOWN;
        end
      end
      SIFT_UP: begin
        if (idx == '0 || !up_hi) begin
          next_state = IDLE;
        end else begin
          we_a     = 1'b1;
          wa_idx   = par_idx;
          wa_data  = cur_val;
          we_b     = 1'b1;
          wb_idx   = idx;
          wb_data  = par_val;
          next_idx = par_idx;
        end
      end
      SIFT_DOWN: begin
        if (!left_in || !dn_hi) begin
          next_state = IDLE;
        end else begin
          we_a     = 1'b1;
          wa_idx   = idx;
          wa_data  = best_val;
          we_b     = 1'b1;
          wb_idx   = best_idx;
          wb_data  = cur_val;
          next_idx = best_idx;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Track whatever lands in slot 0 this cycle so out_data is never a cycle stale.
  always_comb begin
    root_next = arr[0];
    if (we_b && wb_idx == '0) root_next = wb_data;
    if (we_a && wa_idx == '0) root_next = wa_data;
  end

  always_ff @(posedge clk) begin
    if (we_a) arr[wa_idx] <= wa_data;
    if (we_b) arr[wb_idx] <= wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      idx       <= next_idx;
      count     <= next_count;
      in_ready  <= (next_state == IDLE) && (next_count < CNT_W'(DEPTH));
      out_valid <= (next_state == IDLE) && (next_count != '0);
      out_data  <= root_next;
      busy      <= (next_state != IDLE);
    end
  end

endmodule
